// File: rtl/ssd_pkg.sv
// Shared constants and the hex glyph decoder for the seven-segment scan controller.
package ssd_pkg;

  localparam int         PHASE_BITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  // Active-low pattern ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h01;
      4'h1:    seg = 7'h4F;
      4'h2:    seg = 7'h12;
      4'h3:    seg = 7'h06;
      4'h4:    seg = 7'h4C;
      4'h5:    seg = 7'h24;
      4'h6:    seg = 7'h20;
      4'h7:    seg = 7'h0F;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h04;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h60;
      4'hC:    seg = 7'h31;
      4'hD:    seg = 7'h42;
      4'hE:    seg = 7'h30;
      default: seg = 7'h38;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_scan_controller_if.sv
// Data-side bus between game/score logic (master) and the scan controller (slave).
interface ssd_scan_controller_if #(
  parameter int NUM_DIGITS = 8
);

  // load is a one-cycle strobe with no backpressure; pending is high from the
  // cycle after a load until the frame that first displays that data begins.
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic                    lz_blank;
  logic [3:0]              brightness;
  logic                    pending;

  modport master (
    output digits_in, dp_in, digit_en, load, lz_blank, brightness,
    input  pending
  );

  modport slave (
    input  digits_in, dp_in, digit_en, load, lz_blank, brightness,
    output pending
  );

endinterface

// File: rtl/ssd_slot_timer.sv
// Free-running slot counter and digit index; flags slot starts and frame boundaries.
module ssd_slot_timer
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  o_slot_start,
  output logic                  o_boundary,
  output logic [PHASE_BITS-1:0] o_phase,
  output logic [IDX_W-1:0]      o_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_DIV_BITS-1:0] r_slot_cnt;
  logic [IDX_W-1:0]         r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt <= '0;
      r_idx      <= '0;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
      if (r_slot_cnt == '1) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
    end
  end

  assign o_slot_start = (r_slot_cnt == '0);
  assign o_boundary   = o_slot_start && (r_idx == '0);
  assign o_phase      = r_slot_cnt[SCAN_DIV_BITS-1 -: PHASE_BITS];
  assign o_idx        = r_idx;

endmodule

// File: rtl/ssd_scan_controller.sv
// Multiplexed common-anode seven-segment driver with double-buffered data,
// leading-zero blanking and 16-level PWM brightness.
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ssd_scan_controller_if.slave  bus,
  output logic                  frame_start,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW    = 4 * NUM_DIGITS;

  logic                  w_slot_start;
  logic                  w_boundary;
  logic [PHASE_BITS-1:0] w_phase;
  logic [IDX_W-1:0]      w_idx;

  ssd_slot_timer #(
    .NUM_DIGITS    (NUM_DIGITS),
    .SCAN_DIV_BITS (SCAN_DIV_BITS)
  ) u_slot_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_slot_start (w_slot_start),
    .o_boundary   (w_boundary),
    .o_phase      (w_phase),
    .o_idx        (w_idx)
  );

  logic [DW-1:0]         r_sh_digits;
  logic [NUM_DIGITS-1:0] r_sh_dp;
  logic [NUM_DIGITS-1:0] r_sh_en;
  logic [DW-1:0]         r_act_digits;
  logic [NUM_DIGITS-1:0] r_act_dp;
  logic [NUM_DIGITS-1:0] r_act_en;
  logic                  r_pending;

  logic [PHASE_BITS-1:0] r_bright;
  logic                  r_lit;
  logic [6:0]            r_seg_n;
  logic                  r_dp_n;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic                  r_frame_start;

  logic                  w_commit;
  logic [DW-1:0]         w_act_digits;
  logic [NUM_DIGITS-1:0] w_act_dp;
  logic [NUM_DIGITS-1:0] w_act_en;
  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic                  w_zero_run;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_en_sel;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_an_next;

  // Digit 0 of a new frame must see the data being committed on this same edge.
  assign w_commit     = w_boundary && r_pending;
  assign w_act_digits = w_commit ? r_sh_digits : r_act_digits;
  assign w_act_dp     = w_commit ? r_sh_dp     : r_act_dp;
  assign w_act_en     = w_commit ? r_sh_en     : r_act_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_digits  <= '0;
      r_sh_dp      <= '0;
      r_sh_en      <= '0;
      r_act_digits <= '0;
      r_act_dp     <= '0;
      r_act_en     <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (w_commit) begin
        r_act_digits <= r_sh_digits;
        r_act_dp     <= r_sh_dp;
        r_act_en     <= r_sh_en;
      end
      if (bus.load) begin
        r_sh_digits <= bus.digits_in;
        r_sh_dp     <= bus.dp_in;
        r_sh_en     <= bus.digit_en;
      end
      if (bus.load) begin
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Walk from the top digit down; a digit is blank while everything above it is zero.
  always_comb begin
    w_lz_mask  = '0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run   = w_zero_run && (w_act_digits[4*i +: 4] == 4'h0);
      w_lz_mask[i] = bus.lz_blank && w_zero_run;
    end
  end

  always_comb begin
    w_nib    = '0;
    w_dp_sel = 1'b0;
    w_en_sel = 1'b0;
    w_blank  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_nib    = w_act_digits[4*i +: 4];
        w_dp_sel = w_act_dp[i];
        w_en_sel = w_act_en[i];
        w_blank  = w_lz_mask[i];
      end
    end
  end

  always_comb begin
    w_an_next = '1;
    if (r_lit && (w_phase != '0) && (w_phase <= r_bright)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_idx == IDX_W'(i)) begin
          w_an_next[i] = 1'b0;
        end
      end
    end
  end

  // Per-slot state only changes in phase 0, when every anode is already off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bright      <= '0;
      r_lit         <= 1'b0;
      r_seg_n       <= SEG_BLANK;
      r_dp_n        <= 1'b1;
      r_an_n        <= '1;
      r_frame_start <= 1'b0;
    end else begin
      if (w_slot_start) begin
        r_bright <= bus.brightness;
        r_lit    <= w_en_sel && !(w_blank && !w_dp_sel);
        r_seg_n  <= (w_en_sel && !w_blank) ? hex_to_seg(w_nib) : SEG_BLANK;
        r_dp_n   <= !(w_en_sel && w_dp_sel);
      end
      r_an_n        <= w_an_next;
      r_frame_start <= w_boundary;
    end
  end

  assign bus.pending = r_pending;
  assign frame_start = r_frame_start;
  assign an_n        = r_an_n;
  assign seg_n       = r_seg_n;
  assign dp_n        = r_dp_n;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Frame-level scoreboard bench for ssd_scan_controller with 64-cycle slots.
module tb_ssd_scan_controller;

  localparam int ND    = 8;
  localparam int SDB   = 6;
  localparam int SLOT  = 64;
  localparam int FRAME = ND * SLOT;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ssd_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

  logic          frame_start;
  logic [ND-1:0] an_n;
  logic [6:0]    seg_n;
  logic          dp_n;

  ssd_scan_controller #(
    .NUM_DIGITS    (ND),
    .SCAN_DIV_BITS (SDB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .frame_start (frame_start),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n)
  );

  // scoreboard: {care_seg, seg_n[6:0], dp_n, anode_low_cycles[7:0]} per digit
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [6:0]  glyph [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    bus.digits_in = d;
    bus.dp_in     = dp;
    bus.digit_en  = en;
    bus.load      = 1'b1;
    step();
    bus.load      = 1'b0;
    check_val("pending_after_load", bus.pending, 1);
  endtask

  task automatic push_idle();
    for (int i = 0; i < ND; i++) exp_q.push_back({1'b1, 7'h7F, 1'b1, 8'd0});
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en,
                            input logic lz, input logic [3:0] br);
    for (int i = 0; i < ND; i++) begin
      logic [3:0] nib;
      logic       blank;
      logic [6:0] seg;
      logic [7:0] low;
      nib   = d[4*i +: 4];
      blank = lz && (i > 0) && ((d >> (4*i)) == 32'd0);
      seg   = (blank || !en[i]) ? 7'h7F : glyph[nib];
      low   = (en[i] && !(blank && !dp[i])) ? 8'(4 * int'(br)) : 8'd0;
      exp_q.push_back({en[i], seg, ~(dp[i] & en[i]), low});
    end
  endtask

  task automatic sync_fs();
    int t;
    t = 0;
    while (frame_start !== 1'b1 && t < FRAME + 8) begin
      step();
      t++;
    end
    if (frame_start !== 1'b1) check_val("fs_timeout", 0, 1);
  endtask

  // Observes one whole frame starting at frame_start and checks it against the queue.
  task automatic watch_frame(input logic exp_pend);
    logic [6:0] s   [ND];
    logic       d_n [ND];
    int         low [ND];
    int         stray, changes, fs_cnt;
    logic [16:0] e;
    stray = 0; changes = 0; fs_cnt = 0;
    sync_fs();
    check_val("pending_at_frame", bus.pending, exp_pend);
    for (int k = 0; k < FRAME; k++) begin
      int d;
      int j;
      d = k / SLOT;
      j = k % SLOT;
      if (frame_start) fs_cnt++;
      if (j == 0) begin
        s[d] = seg_n; d_n[d] = dp_n; low[d] = 0;
      end else if (seg_n !== s[d] || dp_n !== d_n[d]) begin
        changes++;
      end
      if (an_n[d] === 1'b0) low[d]++;
      for (int b = 0; b < ND; b++) if (b != d && an_n[b] !== 1'b1) stray++;
      if (k < FRAME - 1) step();
    end
    check_val("fs_per_frame", fs_cnt, 1);
    check_val("stray_anode", stray, 0);
    check_val("seg_change_in_slot", changes, 0);
    for (int d = 0; d < ND; d++) begin
      if (exp_q.size() == 0) begin
        check_val("sb_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val($sformatf("low_d%0d", d), low[d], e[7:0]);
        if (e[16]) begin
          check_val($sformatf("seg_d%0d", d), s[d], e[15:9]);
          check_val($sformatf("dp_d%0d", d), d_n[d], e[8]);
        end
      end
    end
  endtask

  initial begin
    bus.digits_in  = '0;
    bus.dp_in      = '0;
    bus.digit_en   = '0;
    bus.load       = 1'b0;
    bus.lz_blank   = 1'b0;
    bus.brightness = '0;
    step(3);
    check_val("rst_an_n", an_n, 8'hFF);
    check_val("rst_seg_n", seg_n, 7'h7F);
    check_val("rst_dp_n", dp_n, 1);
    check_val("rst_pending", bus.pending, 0);
    check_val("rst_frame_start", frame_start, 0);

    rst_n = 1'b1;
    step();
    check_val("first_fs", frame_start, 1);
    push_idle();
    watch_frame(1'b0);
    step();
    check_val("fs_period", frame_start, 1);

    // "A5" with leading-zero blanking at full brightness
    bus.lz_blank   = 1'b1;
    bus.brightness = 4'd15;
    step(10);
    do_load(32'h0000_00A5, 8'h00, 8'hFF);
    push_frame(32'h0000_00A5, 8'h00, 8'hFF, 1'b1, 4'd15);
    watch_frame(1'b0);

    // PWM: brightness 4, then 0, single enabled digit
    bus.lz_blank   = 1'b0;
    bus.brightness = 4'd4;
    step(10);
    do_load(32'h8765_4321, 8'h00, 8'h04);
    push_frame(32'h8765_4321, 8'h00, 8'h04, 1'b0, 4'd4);
    watch_frame(1'b0);
    bus.brightness = 4'd0;
    push_frame(32'h8765_4321, 8'h00, 8'h04, 1'b0, 4'd0);
    watch_frame(1'b0);

    // two loads in one frame: only the second is shown
    bus.brightness = 4'd15;
    step(10);
    do_load(32'h1111_1111, 8'h00, 8'hFF);
    step(100);
    do_load(32'h2222_2222, 8'h00, 8'hFF);
    push_frame(32'h2222_2222, 8'h00, 8'hFF, 1'b0, 4'd15);
    watch_frame(1'b0);

    // load landing exactly on the boundary cycle
    bus.lz_blank = 1'b1;
    step(10);
    do_load(32'h0000_1234, 8'h00, 8'hFF);
    step(FRAME - 11);
    do_load(32'h00C0_FFEE, 8'h80, 8'hFF);
    push_frame(32'h0000_1234, 8'h00, 8'hFF, 1'b1, 4'd15);
    watch_frame(1'b1);
    check_val("pending_between", bus.pending, 1);
    push_frame(32'h00C0_FFEE, 8'h80, 8'hFF, 1'b1, 4'd15);
    watch_frame(1'b0);

    // all-zero value with a decimal point on a blanked digit
    step(10);
    do_load(32'h0000_0000, 8'h04, 8'hFF);
    push_frame(32'h0000_0000, 8'h04, 8'hFF, 1'b1, 4'd15);
    watch_frame(1'b0);

    // asynchronous reset while digit 2 is lit and a load is pending
    step(2 * SLOT + 2);
    do_load(32'h5555_5555, 8'h00, 8'hFF);
    step(8);
    check_val("pre_reset_lit", an_n[2], 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_an_n", an_n, 8'hFF);
    check_val("async_rst_seg_n", seg_n, 7'h7F);
    check_val("async_rst_dp_n", dp_n, 1);
    check_val("async_rst_pending", bus.pending, 0);
    step(2);
    rst_n = 1'b1;
    step();
    check_val("fs_after_reset", frame_start, 1);
    push_idle();
    watch_frame(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
